// File: rtl/mips_result_trace_if.sv
// mips_result_trace read-port bundle.
// master drives rd_valid/rd_data; slave drives rd_ready.
// MIPS_TRACE_OVF_TAG_EN widens rd_data to carry the per-entry overflow bit.
interface mips_result_trace_if;

`ifdef MIPS_TRACE_OVF_TAG_EN
  localparam int DW = 33;
`else
  localparam int DW = 32;
`endif

  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;

  modport master (
    output rd_valid,
    output rd_data,
    input  rd_ready
  );

  modport slave (
    input  rd_valid,
    input  rd_data,
    output rd_ready
  );

endinterface

// File: rtl/mips_result_trace.sv
// mips_result_trace: capture FIFO for the multicycle MIPS core's ALUOut.
// Samples mipsOut/overflow on capture, queues them, and serves them on a
// show-ahead ready/valid port (rd). Counts samples dropped while full
// (saturating) and keeps a sticky overflow flag.
// Ports: clk, rst (sync, active-high), capture, mipsOut, overflow, clr,
//   rd (read port), count, full, empty, drop_cnt, ovf_sticky.
// Option: define MIPS_TRACE_OVF_TAG_EN to store overflow as bit 32 of
//   every entry (33-bit rd_data).
module mips_result_trace #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     capture,
  input  logic [31:0]              mipsOut,
  input  logic                     overflow,
  input  logic                     clr,
  mips_result_trace_if.master      rd,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     ovf_sticky
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

`ifdef MIPS_TRACE_OVF_TAG_EN
  localparam int DW = 33;
`else
  localparam int DW = 32;
`endif

  localparam logic [OCC_W-1:0] OCC_FULL =
    OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] OCC_ONE =
    OCC_W'(1);

  typedef enum logic {
    EMPTY,
    NONEMPTY
  } state_t;

  state_t stateQ;
  state_t stateD;

  logic [DW-1:0]    mem [DEPTH];
  logic [PTR_W-1:0] wrPtrQ;
  logic [PTR_W-1:0] wrPtrD;
  logic [PTR_W-1:0] rdPtrQ;
  logic [PTR_W-1:0] rdPtrD;
  logic [OCC_W-1:0] countQ;
  logic [OCC_W-1:0] countD;
  logic [CNT_W-1:0] dropQ;
  logic [CNT_W-1:0] dropD;
  logic             stickyQ;
  logic             stickyD;

  logic             flush;
  logic             isFull;
  logic             isValid;
  logic             push;
  logic             pop;
  logic             drop;
  logic [DW-1:0]    wrEntry;

  assign flush   = rst || clr;
  assign isFull  = (countQ == OCC_FULL);
  assign isValid = (stateQ == NONEMPTY);

  // A flush beats any capture in the same cycle.
  assign pop  = isValid && rd.rd_ready;
  assign push = capture && !flush &&
                (!isFull || pop);
  assign drop = capture && !flush &&
                isFull && !pop;

`ifdef MIPS_TRACE_OVF_TAG_EN
  assign wrEntry = {overflow, mipsOut};
`else
  assign wrEntry = mipsOut;
`endif

  always_comb begin
    stateD  = stateQ;
    wrPtrD  = wrPtrQ;
    rdPtrD  = rdPtrQ;
    countD  = countQ;
    dropD   = dropQ;
    stickyD = stickyQ;

    unique case (stateQ)
      EMPTY: begin
        if (push) stateD = NONEMPTY;
      end
      NONEMPTY: begin
        if (pop && !push &&
            countQ == OCC_ONE)
          stateD = EMPTY;
      end
      default: stateD = EMPTY;
    endcase

    if (push) wrPtrD = wrPtrQ + 1'b1;
    if (pop)  rdPtrD = rdPtrQ + 1'b1;

    unique case ({push, pop})
      2'b10:   countD = countQ + 1'b1;
      2'b01:   countD = countQ - 1'b1;
      default: countD = countQ;
    endcase

    if (drop && dropQ != '1)
      dropD = dropQ + 1'b1;

    // Dropped samples still raise the flag.
    if (capture && overflow && !flush)
      stickyD = 1'b1;

    if (flush) begin
      stateD  = EMPTY;
      wrPtrD  = '0;
      rdPtrD  = '0;
      countD  = '0;
      dropD   = '0;
      stickyD = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    stateQ  <= stateD;
    wrPtrQ  <= wrPtrD;
    rdPtrQ  <= rdPtrD;
    countQ  <= countD;
    dropQ   <= dropD;
    stickyQ <= stickyD;
  end

  // Storage is never cleared; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtrQ] <= wrEntry;
  end

  assign rd.rd_valid = isValid;
  assign rd.rd_data  = mem[rdPtrQ];

  assign count      = countQ;
  assign full       = isFull;
  assign empty      = (stateQ == EMPTY);
  assign drop_cnt   = dropQ;
  assign ovf_sticky = stickyQ;

endmodule

// File: tb/tb_mips_result_trace.sv
// Testbench for mips_result_trace.
// Scoreboard queues hold accepted samples; reads pop and compare.
module tb_mips_result_trace;

`ifdef MIPS_TRACE_OVF_TAG_EN
  localparam int DW = 33;
`else
  localparam int DW = 32;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        clr;
  logic        capture;
  logic [31:0] mipsOut;
  logic        overflow;
  logic [4:0]  count;
  logic        full;
  logic        empty;
  logic [7:0]  dropCnt;
  logic        ovfSticky;

  logic        clrB;
  logic        captureB;
  logic [31:0] mipsOutB;
  logic        overflowB;
  logic [2:0]  countB;
  logic        fullB;
  logic        emptyB;
  logic [1:0]  dropCntB;
  logic        ovfStickyB;

  mips_result_trace_if ifA ();
  mips_result_trace_if ifB ();

  mips_result_trace #(
    .DEPTH(16),
    .CNT_W(8)
  ) dutA (
    .clk       (clk),
    .rst       (rst),
    .capture   (capture),
    .mipsOut   (mipsOut),
    .overflow  (overflow),
    .clr       (clr),
    .rd        (ifA),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .drop_cnt  (dropCnt),
    .ovf_sticky(ovfSticky)
  );

  mips_result_trace #(
    .DEPTH(4),
    .CNT_W(2)
  ) dutB (
    .clk       (clk),
    .rst       (rst),
    .capture   (captureB),
    .mipsOut   (mipsOutB),
    .overflow  (overflowB),
    .clr       (clrB),
    .rd        (ifB),
    .count     (countB),
    .full      (fullB),
    .empty     (emptyB),
    .drop_cnt  (dropCntB),
    .ovf_sticky(ovfStickyB)
  );

  int passCnt  = 0;
  int totalCnt = 0;

  logic [DW-1:0] qA [$];
  logic [DW-1:0] qB [$];
  int mCntA  = 0;
  int mDropA = 0;
  int mCntB  = 0;
  int mDropB = 0;

  function automatic logic [DW-1:0] mk(
    input logic [31:0] d,
    input logic        ov
  );
`ifdef MIPS_TRACE_OVF_TAG_EN
    return {ov, d};
`else
    return DW'(d) | DW'(ov & 1'b0);
`endif
  endfunction

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capA(
    input logic [31:0] d,
    input logic        ov
  );
    capture  = 1'b1;
    mipsOut  = d;
    overflow = ov;
    if (mCntA < 16) begin
      qA.push_back(mk(d, ov));
      mCntA++;
    end else if (mDropA < 255) begin
      mDropA++;
    end
    tick();
    capture  = 1'b0;
    overflow = 1'b0;
  endtask

  task automatic capB(
    input logic [31:0] d,
    input logic        ov
  );
    captureB  = 1'b1;
    mipsOutB  = d;
    overflowB = ov;
    if (mCntB < 4) begin
      qB.push_back(mk(d, ov));
      mCntB++;
    end else if (mDropB < 3) begin
      mDropB++;
    end
    tick();
    captureB  = 1'b0;
    overflowB = 1'b0;
  endtask

  task automatic readA(input string tag);
    logic [DW-1:0] exp;
    chk({tag, "_valid"}, 64'(ifA.rd_valid), 64'd1);
    if (qA.size() > 0) exp = qA.pop_front();
    else               exp = '0;
    chk({tag, "_data"}, 64'(ifA.rd_data), 64'(exp));
    ifA.rd_ready = 1'b1;
    tick();
    ifA.rd_ready = 1'b0;
    mCntA--;
  endtask

  task automatic readB(input string tag);
    logic [DW-1:0] exp;
    chk({tag, "_valid"}, 64'(ifB.rd_valid), 64'd1);
    if (qB.size() > 0) exp = qB.pop_front();
    else               exp = '0;
    chk({tag, "_data"}, 64'(ifB.rd_data), 64'(exp));
    ifB.rd_ready = 1'b1;
    tick();
    ifB.rd_ready = 1'b0;
    mCntB--;
  endtask

  initial begin
    rst          = 1'b1;
    clr          = 1'b0;
    capture      = 1'b0;
    mipsOut      = '0;
    overflow     = 1'b0;
    clrB         = 1'b0;
    captureB     = 1'b0;
    mipsOutB     = '0;
    overflowB    = 1'b0;
    ifA.rd_ready = 1'b0;
    ifB.rd_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    chk("rst_empty",  64'(empty),        64'd1);
    chk("rst_full",   64'(full),         64'd0);
    chk("rst_count",  64'(count),        64'd0);
    chk("rst_drop",   64'(dropCnt),      64'd0);
    chk("rst_sticky", 64'(ovfSticky),    64'd0);
    chk("rst_valid",  64'(ifA.rd_valid), 64'd0);

    capA(32'h1, 1'b0);
    chk("lat_valid", 64'(ifA.rd_valid), 64'd1);
    chk("lat_data",  64'(ifA.rd_data),  64'd1);
    capA(32'h2, 1'b0);
    capA(32'h3, 1'b0);
    chk("three_count", 64'(count), 64'd3);
    readA("rd1");
    readA("rd2");
    readA("rd3");
    chk("drain_valid", 64'(ifA.rd_valid), 64'd0);
    chk("drain_count", 64'(count),        64'd0);

    for (int i = 0; i < 20; i++)
      capA(32'h100 + 32'(i), 1'b0);
    chk("fill_full",  64'(full),    64'd1);
    chk("fill_count", 64'(count),   64'd16);
    chk("fill_drop",  64'(dropCnt), 64'(mDropA));
    chk("fill_drop4", 64'(dropCnt), 64'd4);

    for (int i = 0; i < 5; i++) begin
      logic [DW-1:0] exp;
      exp = qA.pop_front();
      chk("pp_data", 64'(ifA.rd_data), 64'(exp));
      qA.push_back(mk(32'h200 + 32'(i), 1'b0));
      ifA.rd_ready = 1'b1;
      capture      = 1'b1;
      mipsOut      = 32'h200 + 32'(i);
      tick();
    end
    ifA.rd_ready = 1'b0;
    capture      = 1'b0;
    chk("pp_drop",  64'(dropCnt), 64'd4);
    chk("pp_count", 64'(count),   64'd16);
    chk("pp_full",  64'(full),    64'd1);

    for (int i = 0; i < 16; i++)
      readA("drain");
    chk("drain2_empty", 64'(empty), 64'd1);
    chk("drain2_count", 64'(count), 64'd0);

    capA(32'h7FFFFFFF, 1'b1);
    chk("ovf_sticky", 64'(ovfSticky), 64'd1);
    chk("ovf_data",   64'(ifA.rd_data), 64'(qA[0]));
    capA(32'h5, 1'b0);
    chk("ovf_hold",   64'(ovfSticky), 64'd1);
    chk("ovf_count",  64'(count),     64'd2);

    clr      = 1'b1;
    capture  = 1'b1;
    mipsOut  = 32'hDEAD;
    overflow = 1'b1;
    tick();
    clr      = 1'b0;
    capture  = 1'b0;
    overflow = 1'b0;
    qA.delete();
    mCntA  = 0;
    mDropA = 0;
    chk("clr_count",  64'(count),        64'd0);
    chk("clr_empty",  64'(empty),        64'd1);
    chk("clr_full",   64'(full),         64'd0);
    chk("clr_drop",   64'(dropCnt),      64'd0);
    chk("clr_sticky", 64'(ovfSticky),    64'd0);
    chk("clr_valid",  64'(ifA.rd_valid), 64'd0);
    capA(32'h42, 1'b0);
    chk("post_count", 64'(count), 64'd1);
    readA("post");
    chk("post_empty", 64'(empty), 64'd1);

    for (int i = 0; i < 4; i++)
      capB(32'h300 + 32'(i), 1'b0);
    chk("b_full",   64'(fullB),      64'd1);
    chk("b_sticky0", 64'(ovfStickyB), 64'd0);
    for (int i = 0; i < 6; i++)
      capB(32'h400 + 32'(i), i == 5);
    chk("b_drop_sat", 64'(dropCntB), 64'd3);
    chk("b_drop_mdl", 64'(dropCntB), 64'(mDropB));
    chk("b_sticky1",  64'(ovfStickyB), 64'd1);
    chk("b_count",    64'(countB),   64'd4);
    for (int i = 0; i < 4; i++)
      readB("b_rd");
    chk("b_empty", 64'(emptyB), 64'd1);

    $display("%0d/%0d checks passed",
             passCnt, totalCnt);
    $finish;
  end

endmodule
